cla_pipe_adder: RTL and testbench

Pipelined, parametrised carry-lookahead adder/subtractor for the multiplier datapath. Splits a WIDTH-bit operation into STAGES register-separated slices, each built from GROUP-bit lookahead carry groups with the slice carry-out forwarded to the next stage. It accepts one operation per cycle under a valid/ready handshake and sits after the partial-product reduction tree as the final carry-propagate adder. It also serves as the general add/sub unit for the multiplier's accumulate path.

---
 rtl/cla_pipe_adder.sv | 138 +++++++++++++
 tb/tb_cla_pipe_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. WIDTH bits are split into STAGES
// register-separated slices; each slice is a chain of GROUP-bit lookahead groups.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int C = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH / GROUP || (WIDTH % (GROUP * STAGES)) != 0) begin : g_paramCheck
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES and 1 <= STAGES <= WIDTH/GROUP");
  end

  logic             r_outValid;
  logic [WIDTH-1:0] r_outSum;
  logic             r_outCout;
  logic             r_outOvf;
  logic             w_adv;

  // One slice: carries are flattened inside each group, then ripple group to group.
  // Returns {carry out of the slice, slice sum}.
  function automatic logic [C:0] sliceAdd(input logic [C-1:0] a,
                                          input logic [C-1:0] bp,
                                          input logic         cin);
    logic [C-1:0] p;
    logic [C-1:0] g;
    logic [C:0]   c;
    logic         term;
    logic         prod;
    p    = a ^ bp;
    g    = a & bp;
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < C / GROUP; grp++) begin
      for (int j = 0; j < GROUP; j++) begin
        term = c[grp*GROUP];
        for (int m = 0; m <= j; m++) term = term & p[grp*GROUP+m];
        for (int m = 0; m <= j; m++) begin
          prod = g[grp*GROUP+m];
          for (int n = m + 1; n <= j; n++) prod = prod & p[grp*GROUP+n];
          term = term | prod;
        end
        c[grp*GROUP+j+1] = term;
      end
    end
    return {c[C], p ^ c[C-1:0]};
  endfunction

  assign w_adv     = ~r_outValid | out_ready;
  assign in_ready  = w_adv & ~rst;
  assign out_valid = r_outValid;
  assign out_sum   = r_outSum;
  assign out_cout  = r_outCout;
  assign out_ovf   = r_outOvf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int INW = WIDTH - k * C;

    logic [INW-1:0]     w_a;
    logic [INW-1:0]     w_bp;
    logic               w_cin;
    logic               w_vIn;
    logic [C:0]         w_res;
    logic [(k+1)*C-1:0] w_sum;

    // b is inverted once on entry so later stages never need in_sub.
    if (k == 0) begin : g_src
      assign w_a   = in_a;
      assign w_bp  = in_sub ? ~in_b : in_b;
      assign w_cin = in_sub | in_cin;
      assign w_vIn = in_valid;
      assign w_sum = w_res[C-1:0];
    end else begin : g_src
      assign w_a   = g_stage[k-1].g_pipe.r_a;
      assign w_bp  = g_stage[k-1].g_pipe.r_bp;
      assign w_cin = g_stage[k-1].g_pipe.r_carry;
      assign w_vIn = g_stage[k-1].g_pipe.r_valid;
      assign w_sum = {w_res[C-1:0], g_stage[k-1].g_pipe.r_sum};
    end

    assign w_res = sliceAdd(w_a[C-1:0], w_bp[C-1:0], w_cin);

    if (k < STAGES - 1) begin : g_pipe
      logic               r_valid;
      logic               r_carry;
      logic [INW-C-1:0]   r_a;
      logic [INW-C-1:0]   r_bp;
      logic [(k+1)*C-1:0] r_sum;

      // Interior stage: whole pipe advances together, bubbles included.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_vIn;
          r_carry <= w_res[C];
          r_a     <= w_a[INW-1:C];
          r_bp    <= w_bp[INW-1:C];
          r_sum   <= w_sum;
        end
      end
    end else begin : g_out
      // Output data only loads on a valid beat so it holds across bubbles.
      // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_outValid <= 1'b0;
          r_outSum   <= '0;
          r_outCout  <= 1'b0;
          r_outOvf   <= 1'b0;
        end else if (w_adv) begin
          r_outValid <= w_vIn;
          if (w_vIn) begin
            r_outSum  <= w_sum;
            r_outCout <= w_res[C];
            r_outOvf  <= w_res[C] ^ (w_res[C-1] ^ w_a[C-1] ^ w_bp[C-1]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: three instances (STAGES 1, 2, 8) share
// stimulus; the STAGES=2 instance is scoreboarded against an arithmetic model.
module tb_cla_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          stamp;
    bit          latChk;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_ready;

  logic        inReady  [3];
  logic        outValid [3];
  logic [31:0] outSum   [3];
  logic        outCout  [3];
  logic        outOvf   [3];
  int          stageOf  [3] = '{1, 2, 8};

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  expT         expQ[$];
  int          cycleCount  = 0;
  bit          streamMode  = 0;
  bit          monArmed    = 0;
  bit          prevStalled = 0;
  logic [31:0] holdSum;
  logic        holdCout;
  logic        holdOvf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(outValid[0]), .out_ready(out_ready), .out_sum(outSum[0]),
    .out_cout(outCout[0]), .out_ovf(outOvf[0]));

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(outValid[1]), .out_ready(out_ready), .out_sum(outSum[1]),
    .out_cout(outCout[1]), .out_ovf(outOvf[1]));

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(outValid[2]), .out_ready(out_ready), .out_sum(outSum[2]),
    .out_cout(outCout[2]), .out_ovf(outOvf[2]));

  // Plain-arithmetic reference: 33-bit add, signed overflow from operand/result signs.
  function automatic expT model(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] full;
    expT         e;
    bb       = sub ? ~b : b;
    full     = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    e.sum    = full[31:0];
    e.cout   = full[32];
    e.ovf    = (a[31] == bb[31]) && (full[31] != a[31]);
    e.stamp  = 0;
    e.latChk = 0;
    return e;
  endfunction

  function automatic expT mk(input logic [31:0] sum, input logic cout, input logic ovf);
    expT e;
    e.sum    = sum;
    e.cout   = cout;
    e.ovf    = ovf;
    e.stamp  = 0;
    e.latChk = 0;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
  endtask

  // Single beat into empty pipes; each instance must produce it after exactly STAGES cycles.
  task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub, input expT exp);
    bit seen [3];
    for (int i = 0; i < 3; i++) seen[i] = 0;
    applyStimulus(1'b1, a, b, cin, sub, 1'b1);
    applyStimulus(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (outValid[i] === 1'b1 && !seen[i]) begin
          seen[i] = 1;
          checkOutput($sformatf("%s_lat_s%0d", tag, stageOf[i]), cyc, stageOf[i]);
          checkOutput($sformatf("%s_sum_s%0d", tag, stageOf[i]), outSum[i], exp.sum);
          checkOutput($sformatf("%s_cout_s%0d", tag, stageOf[i]), outCout[i], exp.cout);
          checkOutput($sformatf("%s_ovf_s%0d", tag, stageOf[i]), outOvf[i], exp.ovf);
        end
      end
      if (cyc < 12) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("%s_seen_s%0d", tag, stageOf[i]), seen[i], 1);
  endtask

  // Scoreboard and protocol monitor for the STAGES=2 instance, sampled mid-cycle.
  always @(negedge clk) begin
    expT e;
    cycleCount++;
    if (rst) begin
      expQ.delete();
      holdSum     = '0;
      holdCout    = 1'b0;
      holdOvf     = 1'b0;
      prevStalled = 0;
      monArmed    = 1;
    end else if (monArmed) begin
      if (prevStalled) checkOutput("stall_valid", outValid[1], 1);
      if (prevStalled || outValid[1] !== 1'b1) begin
        checkOutput("hold_sum", outSum[1], holdSum);
        checkOutput("hold_cout", outCout[1], holdCout);
        checkOutput("hold_ovf", outOvf[1], holdOvf);
      end
      if (outValid[1] === 1'b1) begin
        if (out_ready) begin
          checkOutput("beat_expected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("sb_sum", outSum[1], e.sum);
            checkOutput("sb_cout", outCout[1], e.cout);
            checkOutput("sb_ovf", outOvf[1], e.ovf);
            if (e.latChk) checkOutput("stream_latency", cycleCount - e.stamp, 2);
          end
        end else begin
          checkOutput("stall_in_ready", inReady[1], 0);
        end
        holdSum  = outSum[1];
        holdCout = outCout[1];
        holdOvf  = outOvf[1];
      end
      prevStalled = (outValid[1] === 1'b1) && !out_ready;
      if (in_valid && inReady[1] === 1'b1) begin
        e        = model(in_a, in_b, in_cin, in_sub);
        e.stamp  = cycleCount;
        e.latChk = streamMode;
        expQ.push_back(e);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_valid_s%0d", stageOf[i]), outValid[i], 0);
      checkOutput($sformatf("rst_sum_s%0d", stageOf[i]), outSum[i], 0);
      checkOutput($sformatf("rst_cout_s%0d", stageOf[i]), outCout[i], 0);
      checkOutput($sformatf("rst_ovf_s%0d", stageOf[i]), outOvf[i], 0);
      checkOutput($sformatf("rst_in_ready_s%0d", stageOf[i]), inReady[i], 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", inReady[1], 1);

    $display("[TB] directed cases");
    runDirected("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    runDirected("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
    runDirected("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    runDirected("add_cin_ovf", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
    runDirected("add_chain", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0));
    runDirected("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, mk(32'd7, 1'b1, 1'b0));
    runDirected("rand_a", 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1));

    $display("[TB] full-rate stream");
    streamMode = 1;
    for (int n = 0; n < 100; n++)
      applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    streamMode = 0;
    repeat (5) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] random valid/ready");
    for (int n = 0; n < 300; n++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (15) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_empty", expQ.size(), 0);

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b1, 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_4321, 32'h0000_2222, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("pre_reset_valid", outValid[1], 1);
    rst = 1'b1;
    #1;
    checkOutput("in_ready_during_rst", inReady[1], 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    checkOutput("post_rst_valid", outValid[1], 0);
    checkOutput("post_rst_sum", outSum[1], 0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      checkOutput("flushed_no_beat", outValid[1], 0);
    end
    runDirected("after_rst", 32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0,
                model(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0));
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
